snake_body_stream_ctrl: RTL and testbench

//  Once per frame, during vertical blanking, streams the snake body coordinates from the

---
 rtl/snake_body_stream_ctrl.sv | 179 +++++++++++++++++
 tb/tb_snake_body_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_stream_ctrl.sv
// Snake body streamer: copies body RAM into the renderer once per frame
// and shares the single RAM port with the game-logic move/grow engine.
module snake_body_stream_ctrl #(
  parameter int LEN_BIT = 7,
  parameter int LEN_MAX = 128,
  parameter int COORD_W = 7,
  parameter int RD_LAT  = 1
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [LEN_BIT-1:0] snake_length,
  input  logic               logic_req,
  input  logic               logic_done,
  output logic               logic_grant,
  output logic               rd_en,
  output logic [LEN_BIT-1:0] rd_addr,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               en_snake_body,
  output logic [COORD_W-1:0] snake_body_x,
  output logic [COORD_W-1:0] snake_body_y,
  output logic               stream_busy,
  output logic               overrun
);

  // One extra bit so a clamp value of 2**LEN_BIT is representable.
  localparam int CNT_W = LEN_BIT + 1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    PEND,
    STREAM,
    DRAIN
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_in;
  logic [LEN_BIT-1:0] idx;
  logic               start;
  logic               last_rd;
  logic               ovr_nx;
  logic               in_flight;

  // pipe[0..RD_LAT-1]: reads waiting on RAM data; pipe[RD_LAT]: beat out.
  logic [RD_LAT:0]    pipe;

  // Clamp the sampled length so the burst never exceeds LEN_MAX beats.
  always_comb begin
    len_in = {1'b0, snake_length};
    if (len_in > CNT_W'(LEN_MAX)) begin
      len_in = CNT_W'(LEN_MAX);
    end
  end

  assign last_rd   = ({1'b0, idx} == (len_q - CNT_W'(1)));
  assign in_flight = |pipe[RD_LAT-1:0];

  // Next-state and control decode; streaming wins ties with game logic.
  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    ovr_nx      = 1'b0;
    rd_en       = 1'b0;
    logic_grant = 1'b0;
    stream_busy = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx = STREAM;
          start    = 1'b1;
        end else if (logic_req) begin
          state_nx = GRANT;
        end
      end
      GRANT: begin
        logic_grant = 1'b1;
        if (logic_done) begin
          if (frame_start) begin
            state_nx = STREAM;
            start    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (frame_start) begin
          state_nx = PEND;
        end
      end
      PEND: begin
        logic_grant = 1'b1;
        ovr_nx      = frame_start;
        if (logic_done) begin
          state_nx = STREAM;
          start    = 1'b1;
        end
      end
      STREAM: begin
        ovr_nx = frame_start;
        if (len_q == '0) begin
          state_nx = IDLE;
        end else begin
          rd_en       = 1'b1;
          stream_busy = 1'b1;
          if (last_rd) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        ovr_nx      = frame_start;
        stream_busy = 1'b1;
        if (!in_flight) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign rd_addr       = rd_en ? idx : '0;
  assign en_snake_body = pipe[RD_LAT];

  // State register.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Burst length latch and read address counter.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      idx   <= '0;
    end else if (start) begin
      len_q <= len_in;
      idx   <= '0;
    end else if (rd_en) begin
      idx <= idx + LEN_BIT'(1);
    end
  end

  // Read-valid pipeline; the last stage is the beat strobe itself.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[RD_LAT-1:0], rd_en};
    end
  end

  // Capture returning RAM data; hold it between bursts.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      snake_body_x <= '0;
      snake_body_y <= '0;
    end else if (pipe[RD_LAT-1]) begin
      snake_body_x <= rd_x;
      snake_body_y <= rd_y;
    end
  end

  // Registered overrun pulse for frames that arrive while busy.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_snake_body_stream_ctrl.sv
// Bench for snake_body_stream_ctrl: per-cycle vector table plus
// hand-written long-burst, clamp, overrun and mid-burst reset sequences.
module tb_snake_body_stream_ctrl;

  localparam int LEN_BIT = 7;
  localparam int LEN_MAX = 100;
  localparam int COORD_W = 7;
  localparam int RD_LAT  = 1;

  logic               clock_25 = 1'b0;
  logic               reset = 1'b0;
  logic               frame_start = 1'b0;
  logic [LEN_BIT-1:0] snake_length = '0;
  logic               logic_req = 1'b0;
  logic               logic_done = 1'b0;
  logic               logic_grant;
  logic               rd_en;
  logic [LEN_BIT-1:0] rd_addr;
  logic [COORD_W-1:0] rd_x = '0;
  logic [COORD_W-1:0] rd_y = '0;
  logic               en_snake_body;
  logic [COORD_W-1:0] snake_body_x;
  logic [COORD_W-1:0] snake_body_y;
  logic               stream_busy;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  snake_body_stream_ctrl #(
    .LEN_BIT(LEN_BIT),
    .LEN_MAX(LEN_MAX),
    .COORD_W(COORD_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock_25     (clock_25),
    .reset        (reset),
    .frame_start  (frame_start),
    .snake_length (snake_length),
    .logic_req    (logic_req),
    .logic_done   (logic_done),
    .logic_grant  (logic_grant),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .en_snake_body(en_snake_body),
    .snake_body_x (snake_body_x),
    .snake_body_y (snake_body_y),
    .stream_busy  (stream_busy),
    .overrun      (overrun)
  );

  always #20 clock_25 = ~clock_25;

  function automatic logic [COORD_W-1:0] ram_x(input int a);
    return COORD_W'(a * 3 + 1);
  endfunction

  function automatic logic [COORD_W-1:0] ram_y(input int a);
    return COORD_W'(a ^ 'h2A);
  endfunction

  // Body RAM model, one-cycle read latency.
  always @(posedge clock_25) begin
    if (rd_en) begin
      rd_x <= ram_x(int'(rd_addr));
      rd_y <= ram_y(int'(rd_addr));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       fs;
    logic [6:0] len;
    logic       req;
    logic       done;
    logic       e_rd;
    int         e_addr;
    logic       e_gnt;
    logic       e_en;
    logic       e_busy;
    logic       e_ovr;
    int         e_k;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic fs, input int len, input logic req, input logic done,
    input logic rd, input int addr, input logic gnt, input logic en,
    input logic busy, input logic ovr, input int k);
    vec_t v;
    v.fs = fs; v.len = 7'(len); v.req = req; v.done = done;
    v.e_rd = rd; v.e_addr = addr; v.e_gnt = gnt; v.e_en = en;
    v.e_busy = busy; v.e_ovr = ovr; v.e_k = k;
    return v;
  endfunction

  // Runs one frame_start-triggered burst and measures it at negedges.
  task automatic run_burst(
    input int len, input int fs_beat, input int rst_beat,
    output int rd_cnt, output int max_addr, output int beats,
    output int contig, output int data_err, output int ovr_cnt,
    output int addr_err, output int timed_out);
    int first_c, last_c;
    bit fs_go, fired, seen, fin;
    rd_cnt = 0; max_addr = 0; beats = 0; data_err = 0;
    ovr_cnt = 0; addr_err = 0; first_c = -1; last_c = -1;
    fs_go = 0; fired = 0; seen = 0; fin = 0;
    snake_length = 7'(len);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clock_25); #1;
      frame_start = (c == 0) || fs_go;
      fs_go = 0;
      @(negedge clock_25);
      if (rd_en) begin
        if (int'(rd_addr) != rd_cnt) addr_err++;
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        rd_cnt++;
      end
      if (en_snake_body) begin
        if (snake_body_x != ram_x(beats)) data_err++;
        if (snake_body_y != ram_y(beats)) data_err++;
        if (first_c < 0) first_c = c;
        last_c = c;
        beats++;
        if (beats == fs_beat && !fired) begin
          fs_go = 1;
          fired = 1;
        end
      end
      if (overrun) ovr_cnt++;
      if (stream_busy) seen = 1;
      else if (seen) fin = 1;
      if (rst_beat > 0 && beats == rst_beat) begin
        #5 reset = 1'b0;
        #1;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_en", int'(en_snake_body), 0);
        chk("rst_busy", int'(stream_busy), 0);
        chk("rst_grant", int'(logic_grant), 0);
        chk("rst_x", int'(snake_body_x), 0);
        chk("rst_y", int'(snake_body_y), 0);
        chk("rst_ovr", int'(overrun), 0);
        #4 reset = 1'b1;
        fin = 1;
      end
    end
    frame_start = 1'b0;
    contig = (beats > 0) && ((last_c - first_c + 1) == beats);
    timed_out = !fin;
  endtask

  int rd_cnt, max_addr, beats, contig, data_err, ovr_cnt, addr_err, tmo;

  initial begin
    // L=5 burst from IDLE.
    vecs.push_back(mk(1,5,0,0, 0,0, 0,0,0,0,-1));
    vecs.push_back(mk(0,5,0,0, 1,0, 0,0,1,0,-1));
    vecs.push_back(mk(0,5,0,0, 1,1, 0,0,1,0,-1));
    vecs.push_back(mk(0,5,0,0, 1,2, 0,1,1,0, 0));
    vecs.push_back(mk(0,5,0,0, 1,3, 0,1,1,0, 1));
    vecs.push_back(mk(0,5,0,0, 1,4, 0,1,1,0, 2));
    vecs.push_back(mk(0,5,0,0, 0,0, 0,1,1,0, 3));
    vecs.push_back(mk(0,5,0,0, 0,0, 0,1,1,0, 4));
    vecs.push_back(mk(0,5,0,0, 0,0, 0,0,0,0, 4));
    // Grant, frame pended at +3, released at +10, L=3.
    vecs.push_back(mk(0,3,1,0, 0,0, 0,0,0,0, 4));
    vecs.push_back(mk(0,3,1,0, 0,0, 1,0,0,0,-1));
    vecs.push_back(mk(0,3,1,0, 0,0, 1,0,0,0,-1));
    vecs.push_back(mk(1,3,1,0, 0,0, 1,0,0,0,-1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,3,1,0, 0,0, 1,0,0,0,-1));
    vecs.push_back(mk(0,3,0,1, 0,0, 1,0,0,0,-1));
    vecs.push_back(mk(0,3,0,0, 1,0, 0,0,1,0,-1));
    vecs.push_back(mk(0,3,0,0, 1,1, 0,0,1,0,-1));
    vecs.push_back(mk(0,3,0,0, 1,2, 0,1,1,0, 0));
    vecs.push_back(mk(0,3,0,0, 0,0, 0,1,1,0, 1));
    vecs.push_back(mk(0,3,0,0, 0,0, 0,1,1,0, 2));
    vecs.push_back(mk(0,3,0,0, 0,0, 0,0,0,0, 2));
    // L=2, req held off during burst, frame overrun in DRAIN.
    vecs.push_back(mk(1,2,0,0, 0,0, 0,0,0,0, 2));
    vecs.push_back(mk(0,2,1,0, 1,0, 0,0,1,0,-1));
    vecs.push_back(mk(0,2,1,0, 1,1, 0,0,1,0,-1));
    vecs.push_back(mk(1,2,1,0, 0,0, 0,1,1,0, 0));
    vecs.push_back(mk(0,2,1,0, 0,0, 0,1,1,1, 1));
    vecs.push_back(mk(0,2,1,0, 0,0, 0,0,0,0, 1));
    vecs.push_back(mk(0,2,1,1, 0,0, 1,0,0,0,-1));
    vecs.push_back(mk(0,2,0,0, 0,0, 0,0,0,0, 1));
    // L=0: nothing streamed; request granted two cycles later.
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0,0, 1));
    vecs.push_back(mk(0,0,1,0, 0,0, 0,0,0,0, 1));
    vecs.push_back(mk(0,0,1,0, 0,0, 0,0,0,0, 1));
    vecs.push_back(mk(0,0,0,1, 0,0, 1,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 1));

    repeat (3) @(negedge clock_25);
    chk("reset_grant", int'(logic_grant), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_en", int'(en_snake_body), 0);
    chk("reset_busy", int'(stream_busy), 0);
    chk("reset_ovr", int'(overrun), 0);
    chk("reset_x", int'(snake_body_x), 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clock_25); #1;
      frame_start  = vecs[i].fs;
      snake_length = vecs[i].len;
      logic_req    = vecs[i].req;
      logic_done   = vecs[i].done;
      @(negedge clock_25);
      chk($sformatf("v%0d_rd_en", i), int'(rd_en), int'(vecs[i].e_rd));
      chk($sformatf("v%0d_rd_addr", i), int'(rd_addr), vecs[i].e_addr);
      chk($sformatf("v%0d_grant", i), int'(logic_grant), int'(vecs[i].e_gnt));
      chk($sformatf("v%0d_en", i), int'(en_snake_body), int'(vecs[i].e_en));
      chk($sformatf("v%0d_busy", i), int'(stream_busy), int'(vecs[i].e_busy));
      chk($sformatf("v%0d_ovr", i), int'(overrun), int'(vecs[i].e_ovr));
      if (vecs[i].e_k >= 0) begin
        chk($sformatf("v%0d_x", i), int'(snake_body_x),
            int'(ram_x(vecs[i].e_k)));
        chk($sformatf("v%0d_y", i), int'(snake_body_y),
            int'(ram_y(vecs[i].e_k)));
      end
    end
    @(posedge clock_25); #1;
    frame_start = 0; logic_req = 0; logic_done = 0;

    // Clamp: length 127 against LEN_MAX=100, overrun at beat 50.
    run_burst(127, 50, 0, rd_cnt, max_addr, beats, contig,
              data_err, ovr_cnt, addr_err, tmo);
    chk("clamp_timeout", tmo, 0);
    chk("clamp_reads", rd_cnt, LEN_MAX);
    chk("clamp_max_addr", max_addr, LEN_MAX - 1);
    chk("clamp_addr_seq", addr_err, 0);
    chk("clamp_beats", beats, LEN_MAX);
    chk("clamp_contig", contig, 1);
    chk("clamp_data", data_err, 0);
    chk("clamp_overrun", ovr_cnt, 1);

    // Reset at beat 3 of 8, then a clean 8-beat burst.
    run_burst(8, 0, 3, rd_cnt, max_addr, beats, contig,
              data_err, ovr_cnt, addr_err, tmo);
    chk("rst_first_beats", beats, 3);
    run_burst(8, 0, 0, rd_cnt, max_addr, beats, contig,
              data_err, ovr_cnt, addr_err, tmo);
    chk("post_rst_timeout", tmo, 0);
    chk("post_rst_reads", rd_cnt, 8);
    chk("post_rst_beats", beats, 8);
    chk("post_rst_contig", contig, 1);
    chk("post_rst_data", data_err, 0);
    chk("post_rst_ovr", ovr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
